uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

- Shares the single simpleuart transmitter among NUM_REQ byte-stream requesters, for example CPU console, boot monitor, debug/trace logger.
- Arbitrates round-robin, captures one byte per grant and drives the UART data-register write port. Holds each write until the UART stops signalling wait.
- Sits between the requesters and the UART's reg_dat_we/reg_dat_di/reg_dat_wait pins, in place of a direct bus write to the DATA register.

## Interface
Parameters:
- NUM_REQ, default 4: number of requesters, range 2..8.
- LOCK_TIMEOUT, default 1024: idle cycles before a line lock is released. Used only with line lock, range 1..65535.

Ports:
- clk  in  1  clock
- resetn  in  1  reset; synchronous, active-low
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i]
- req_ready  out  NUM_REQ  one-hot byte accept, combinational
- uart_enabled  in  1  UART enabled flag
- uart_dat_we  out  1  to UART reg_dat_we
- uart_dat_di  out  32  to UART reg_dat_di; bits [31:8] always 0
- uart_dat_wait  in  1  from UART reg_dat_wait
- grant_id  out  clog2(NUM_REQ)  index of the last granted requester
- busy  out  1  high in any state other than IDLE

## Operation
States: IDLE, SEND, LOCK (LOCK exists only with line lock compiled in).

IDLE
- If uart_enabled=1 and any req_valid is set, pick winner w by round-robin. Search starts at rr_ptr and increments modulo NUM_REQ.
- Assert req_ready[w] in the same cycle. Capture req_data[w] into byte_q, load w into grant_id, set rr_ptr=(w+1) mod NUM_REQ, go to SEND.
- If uart_enabled=0, req_ready stays 0 and no grant is made.

SEND
- Drive uart_dat_we=1 and uart_dat_di={24'h0,byte_q}.
- The write is accepted on the first cycle with uart_dat_we=1 and uart_dat_wait=0.
- On acceptance:
  - With line lock, byte_q!=8'h0A: go to LOCK and clear lock_cnt.
  - Otherwise: go to IDLE.
- uart_enabled falling during SEND does not abort; the byte completes.

LOCK
- Only requester grant_id can be served.
- If req_valid[grant_id]=1: assert req_ready[grant_id], capture its byte, go to SEND. rr_ptr is unchanged.
- Else increment lock_cnt. When lock_cnt reaches LOCK_TIMEOUT-1, go to IDLE without a grant. Other requesters wait.

Boundary cases
- Only one requester valid: it wins regardless of rr_ptr.
- rr_ptr wraps from NUM_REQ-1 to 0.
- Requests arriving during SEND or LOCK are held off (req_ready=0); requesters must keep valid and data stable until ready.
- At most one req_ready bit is high in any cycle.
- Reset mid-SEND drops byte_q. The UART is never left with uart_dat_we asserted.

## Timing
- Reset values: state=IDLE, req_ready=0, uart_dat_we=0, uart_dat_di=0, grant_id=0, busy=0, rr_ptr=0, lock_cnt=0.
- req_ready is combinational from state, req_valid, rr_ptr and uart_enabled. byte_q, grant_id and state are registered.
- Byte accepted in cycle t (IDLE) → uart_dat_we=1 in cycle t+1.
- If uart_dat_wait=0 at t+1, the write completes at t+1 and the block is back in IDLE at t+2.
- Peak rate is one byte per 2 cycles; the UART serial rate is always the limiting factor.
- The lock timeout counts LOCK_TIMEOUT cycles spent in LOCK.

## Configuration
- UART_ARB_LINE_LOCK_EN defined:
  - After a granted byte, the grant stays with that requester until it sends 8'h0A or idles for LOCK_TIMEOUT cycles.
  - Prevents interleaved log lines.
- Undefined:
  - LOCK state, lock_cnt and the LOCK_TIMEOUT logic are removed.
  - Every byte is arbitrated independently.
  - LOCK_TIMEOUT is ignored.

## Structure
- Package uart_arb_pkg holds:
  - state enum (IDLE, SEND, LOCK)
  - LF constant 8'h0A
  - grant index width function clog2
- Sub-module rr_pick: purely combinational. Inputs are the valid vector and rr_ptr; outputs are a one-hot grant and an index. Instantiated once.

## Test plan
- NUM_REQ=4, requesters 0 and 2 each send one byte (8'h41, 8'h42), uart_dat_wait=0 → UART writes 8'h41 then 8'h42, 2 cycles apart; grant_id=0 then 2.
- All four requesters valid continuously, line lock undefined → grant order 0,1,2,3,0,… with no requester granted twice before the others.
- uart_dat_wait held high 50 cycles in SEND → uart_dat_we and uart_dat_di stable for 51 cycles; exactly one write; all req_ready=0 throughout.
- Line lock: requester 1 sends "AB\n" while requester 0 is valid → bytes 41,42,0A from requester 1 are contiguous, then requester 0 is granted.
- Line lock, LOCK_TIMEOUT=16: requester 1 sends one byte then drops valid → requester 0 is granted 16 cycles after the LOCK entry.
- uart_enabled=0 with requests pending → no req_ready and no uart_dat_we; assert resetn=0 during SEND → uart_dat_we=0 and busy=0 on the next cycle.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg
//   Shared definitions for the UART transmit arbiter: FSM state encoding,
//   the line-feed byte that terminates a locked line, and the clog2 helper
//   used to size requester index ports.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_LOCK = 2'd2
  } arb_state_e;

  localparam logic [7:0] LF = 8'h0A;

  // Index width for n requesters; never returns less than 1 bit.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin picker. Scans the valid vector starting at
//   ptr and wrapping modulo NUM_REQ; the first set bit wins.
// Ports:
//   valid  in   NUM_REQ  request vector
//   ptr    in   IDX_W    first index to consider
//   grant  out  NUM_REQ  one-hot winner (0 when nothing valid)
//   idx    out  IDX_W    winner index (0 when nothing valid)
//   any    out  1        some request is valid
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    grant    = '0;
    idx      = '0;
    any      = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!any && valid[cand_idx]) begin
        any             = 1'b1;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one simpleuart transmitter among NUM_REQ byte-stream requesters.
//   Round-robin grant in IDLE, one byte captured per grant, and the UART
//   data-register write is held until reg_dat_wait drops.
//   Optional line lock (macro UART_ARB_LINE_LOCK_EN): after a byte other
//   than LF, the grant stays with the same requester until it sends LF or
//   idles for LOCK_TIMEOUT cycles.
// Ports:
//   clk, resetn      clock, synchronous active-low reset
//   req_valid/data   per-requester byte valid and byte (8 bits each)
//   req_ready        one-hot accept, combinational
//   uart_enabled     grants in IDLE only while set
//   uart_dat_we/di   UART reg_dat_we / reg_dat_di
//   uart_dat_wait    UART reg_dat_wait
//   grant_id         last granted requester
//   busy             not IDLE
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [8*NUM_REQ-1:0]        req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        uart_enabled,
  output logic                        uart_dat_we,
  output logic [31:0]                 uart_dat_di,
  input  logic                        uart_dat_wait,
  output logic [clog2(NUM_REQ)-1:0]   grant_id,
  output logic                        busy
);

  localparam int         IDX_W = clog2(NUM_REQ);
  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] SEND  = ST_SEND;
`ifdef UART_ARB_LINE_LOCK_EN
  localparam logic [1:0]  LOCK      = ST_LOCK;
  localparam logic [15:0] LOCK_LAST = 16'(LOCK_TIMEOUT - 1);
`endif

  if (NUM_REQ < 2 || NUM_REQ > 8 || LOCK_TIMEOUT < 1 || LOCK_TIMEOUT > 65535) begin : g_param_check
    $error("uart_tx_arbiter: NUM_REQ or LOCK_TIMEOUT out of range");
  end

  logic [1:0]       state_q;
  logic [7:0]       byte_q;
  logic [IDX_W-1:0] grant_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] ptr_next;
  logic [7:0]       req_byte [NUM_REQ];
  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             take_idle;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_byte[i] = req_data[8*i +: 8];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .valid (req_valid),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // resetn gates the accept so no requester sees a handshake that reset drops.
  assign take_idle = resetn && (state_q == IDLE) && uart_enabled && pick_any;
  assign ptr_next  = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;

`ifdef UART_ARB_LINE_LOCK_EN
  logic        take_lock;
  logic [15:0] lock_cnt_q;
  assign take_lock = resetn && (state_q == LOCK) && req_valid[grant_q];
`endif

  always_comb begin
    req_ready = '0;
    if (take_idle) req_ready = pick_grant;
`ifdef UART_ARB_LINE_LOCK_EN
    if (take_lock) req_ready[grant_q] = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      byte_q   <= '0;
      grant_q  <= '0;
      rr_ptr_q <= '0;
`ifdef UART_ARB_LINE_LOCK_EN
      lock_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (take_idle) begin
            byte_q   <= req_byte[pick_idx];
            grant_q  <= pick_idx;
            rr_ptr_q <= ptr_next;
            state_q  <= SEND;
          end
        end
        SEND: begin
          if (!uart_dat_wait) begin
`ifdef UART_ARB_LINE_LOCK_EN
            if (byte_q != LF) begin
              state_q    <= LOCK;
              lock_cnt_q <= '0;
            end else begin
              state_q <= IDLE;
            end
`else
            state_q <= IDLE;
`endif
          end
        end
`ifdef UART_ARB_LINE_LOCK_EN
        LOCK: begin
          // rr_ptr stays put so the requester after the lock owner goes next.
          if (take_lock) begin
            byte_q  <= req_byte[grant_q];
            state_q <= SEND;
          end else if (lock_cnt_q == LOCK_LAST) begin
            state_q <= IDLE;
          end else begin
            lock_cnt_q <= lock_cnt_q + 16'd1;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign uart_dat_we = (state_q == SEND);
  assign uart_dat_di = (state_q == SEND) ? {24'h0, byte_q} : 32'h0;
  assign grant_id    = grant_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;
  localparam logic [7:0] LF_B = 8'h0A;

  logic         clk = 1'b0;
  logic         resetn;
  logic [N-1:0] req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0] req_ready;
  logic         uart_enabled;
  logic         uart_dat_we;
  logic [31:0]  uart_dat_di;
  logic         uart_dat_wait;
  logic [1:0]   grant_id;
  logic         busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(TO)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .uart_enabled  (uart_enabled),
    .uart_dat_we   (uart_dat_we),
    .uart_dat_di   (uart_dat_di),
    .uart_dat_wait (uart_dat_wait),
    .grant_id      (grant_id),
    .busy          (busy)
  );

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0] src [N][16];
  int         len [N];
  int         start [N];
  int         exp_id [$];
  logic [7:0] exp_byte [$];
  int         wr_cyc [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    req_valid = '0;
    req_data = '0;
    uart_dat_wait = 1'b0;
    uart_enabled = 1'b1;
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic clear_streams();
    for (int i = 0; i < N; i++) begin
      len[i] = 0;
      start[i] = 0;
    end
    exp_id.delete();
    exp_byte.delete();
  endtask

  // Transaction-level reference: who sends which byte, in order. Requesters
  // with bytes left are always valid, so order depends only on the queues.
  task automatic build_expected();
    int pos [N];
    int ptr, lock, w, c, left;
    logic [7:0] b;
    ptr = 0;
    lock = -1;
    left = 0;
    for (int i = 0; i < N; i++) begin
      pos[i] = 0;
      left += len[i];
    end
    while (left > 0) begin
      w = -1;
      if (lock >= 0 && pos[lock] < len[lock]) begin
        w = lock;
      end else begin
        lock = -1;
        for (int k = 0; k < N; k++) begin
          c = (ptr + k) % N;
          if (w < 0 && pos[c] < len[c]) w = c;
        end
        ptr = (w + 1) % N;
      end
      b = src[w][pos[w]];
      pos[w]++;
      left--;
      exp_id.push_back(w);
      exp_byte.push_back(b);
`ifdef UART_ARB_LINE_LOCK_EN
      lock = (b != LF_B) ? w : -1;
`endif
    end
  endtask

  task automatic run_stream(input int budget, input int wait_pct);
    int pos [N];
    int cyc, nwr, last_rdy, idx;
    bit prev_stall;
    logic [31:0] prev_di;
    cyc = 0;
    nwr = 0;
    last_rdy = -10;
    prev_stall = 0;
    prev_di = '0;
    wr_cyc.delete();
    for (int i = 0; i < N; i++) pos[i] = 0;
    while (nwr < exp_id.size() && cyc < budget) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i] = (cyc >= start[i]) && (pos[i] < len[i]);
        req_data[8*i +: 8] = req_valid[i] ? src[i][pos[i]] : 8'($urandom);
      end
      uart_dat_wait = ($urandom_range(99) < wait_pct);
      #1;
      check("ready_onehot", {31'h0, ($countones(req_ready) <= 1)}, 32'h1);
      check("ready_unrequested", req_ready & ~req_valid, 0);
      if (uart_dat_we) begin
        check("ready_in_send", req_ready, 0);
        check("di_upper_zero", uart_dat_di[31:8], 0);
      end
      if (prev_stall) begin
        check("stall_we", uart_dat_we, 1);
        check("stall_di", uart_dat_di, prev_di);
      end
      if (last_rdy == cyc - 1) check("accept_to_we", uart_dat_we, 1);
      if (uart_dat_we && !uart_dat_wait) begin
        check("wr_id", grant_id, exp_id[nwr]);
        check("wr_byte", uart_dat_di[7:0], exp_byte[nwr]);
        wr_cyc.push_back(cyc);
        nwr++;
      end
      if (req_ready != 0) begin
        idx = 0;
        for (int i = 0; i < N; i++) if (req_ready[i]) idx = i;
        pos[idx]++;
        last_rdy = cyc;
      end
      prev_stall = uart_dat_we && uart_dat_wait;
      prev_di = uart_dat_di;
      tick();
      cyc++;
    end
    check("writes_done", nwr, exp_id.size());
    req_valid = '0;
    uart_dat_wait = 1'b0;
  endtask

  initial begin
    int nwe, n;

    // Reset values, with requests pending during reset.
    resetn = 1'b0;
    uart_enabled = 1'b1;
    uart_dat_wait = 1'b0;
    req_valid = 4'hF;
    req_data = $urandom;
    tick();
    tick();
    check("rst_ready", req_ready, 0);
    check("rst_we", uart_dat_we, 0);
    check("rst_di", uart_dat_di, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_busy", busy, 0);

    // Requesters 0 and 2 each send one byte.
    do_reset();
    clear_streams();
    len[0] = 1; src[0][0] = 8'h41;
    len[2] = 1; src[2][0] = 8'h42;
    build_expected();
    run_stream(200, 0);
`ifndef UART_ARB_LINE_LOCK_EN
    check("two_byte_spacing", wr_cyc[1] - wr_cyc[0], 2);
`endif

    // All four requesters valid continuously.
    do_reset();
    clear_streams();
    for (int i = 0; i < N; i++) begin
      len[i] = 5;
      for (int j = 0; j < 5; j++) src[i][j] = 8'($urandom);
    end
    build_expected();
    run_stream(400, 0);

    // UART wait held for 50 cycles in SEND.
    do_reset();
    req_valid = 4'b1010;
    req_data = {8'h77, 8'h00, 8'h5A, 8'h00};
    #1;
    check("w50_grant", req_ready, 4'b0010);
    tick();
    req_valid = 4'b1000;
    uart_dat_wait = 1'b1;
    nwe = 0;
    for (int i = 0; i < 50; i++) begin
      #1;
      check("w50_we", uart_dat_we, 1);
      check("w50_di", uart_dat_di, 32'h5A);
      check("w50_ready", req_ready, 0);
      if (uart_dat_we) nwe++;
      tick();
    end
    uart_dat_wait = 1'b0;
    #1;
    check("w50_final_di", uart_dat_di, 32'h5A);
    if (uart_dat_we) nwe++;
    tick();
    #1;
    check("w50_we_cycles", nwe, 51);
    check("w50_after_we", uart_dat_we, 0);
`ifdef UART_ARB_LINE_LOCK_EN
    check("w50_after_ready", req_ready, 0);
    check("w50_after_busy", busy, 1);
`else
    check("w50_after_ready", req_ready, 4'b1000);
`endif

    // Randomized streams with random UART back-pressure.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      clear_streams();
      for (int i = 0; i < N; i++) begin
        len[i] = $urandom_range(0, 8);
        for (int j = 0; j < 16; j++)
          src[i][j] = ($urandom_range(3) == 0) ? LF_B : 8'($urandom);
      end
      build_expected();
      run_stream(3000, 30);
    end

`ifdef UART_ARB_LINE_LOCK_EN
    // Requester 1 sends "AB\n" while requester 0 becomes valid.
    do_reset();
    clear_streams();
    len[1] = 3;
    src[1][0] = 8'h41; src[1][1] = 8'h42; src[1][2] = 8'h0A;
    len[0] = 1; src[0][0] = 8'h55;
    start[0] = 1;
    exp_id = '{1, 1, 1, 0};
    exp_byte = '{8'h41, 8'h42, 8'h0A, 8'h55};
    run_stream(300, 0);

    // Lock timeout: requester 0 granted TO cycles after LOCK entry.
    do_reset();
    req_valid = 4'b0010;
    req_data = {8'h00, 8'h00, 8'h31, 8'h00};
    #1;
    check("to_grant1", req_ready, 4'b0010);
    tick();
    req_valid = 4'b0001;
    req_data = {8'h00, 8'h00, 8'h00, 8'h30};
    #1;
    check("to_send_we", uart_dat_we, 1);
    tick();
    n = 0;
    while (n < 100) begin
      #1;
      if (req_ready[0]) break;
      n++;
      tick();
    end
    check("lock_timeout_cycles", n, TO);
`endif

    // UART disabled, then reset asserted mid-SEND.
    do_reset();
    uart_enabled = 1'b0;
    req_valid = 4'hF;
    req_data = $urandom;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("dis_ready", req_ready, 0);
      check("dis_we", uart_dat_we, 0);
      check("dis_busy", busy, 0);
      tick();
    end
    uart_enabled = 1'b1;
    #1;
    check("en_grant", req_ready, 4'b0001);
    tick();
    req_valid = 4'hE;
    uart_dat_wait = 1'b1;
    #1;
    check("rst_send_we", uart_dat_we, 1);
    resetn = 1'b0;
    tick();
    check("rst_mid_we", uart_dat_we, 0);
    check("rst_mid_busy", busy, 0);
    resetn = 1'b1;
    uart_dat_wait = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
